channel_noise_adder: RTL

CHANNEL_NOISE_ADDER -- requirements
Module: channel_noise_adder

---
 rtl/channel_noise_adder.sv | 127 ++++++++++++
 1 files changed

// File: rtl/channel_noise_adder.sv
// Adds upstream Gaussian noise to I/Q symbols behind an IDLE/WARMUP/RUN gate, then saturates to S(8,7).
// Optional saturation counter enabled by defining CHANNEL_SAT_CNT_EN.
module channel_noise_adder #(
  parameter int unsigned NBT_DATA      = 8,
  parameter int unsigned NBF_DATA      = 7,
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter int unsigned NB_SAT_CNT    = 16
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic [NBT_DATA-1:0]   i_sym_I,
  input  logic [NBT_DATA-1:0]   i_sym_Q,
  input  logic [NBT_DATA-1:0]   i_noise_I,
  input  logic [NBT_DATA-1:0]   i_noise_Q,
  output logic                  o_valid,
  output logic [NBT_DATA-1:0]   o_rx_I,
  output logic [NBT_DATA-1:0]   o_rx_Q,
  output logic [NB_SAT_CNT-1:0] o_sat_count
);

  localparam int unsigned NBS       = NBT_DATA + 1;
  localparam int unsigned CNT_W     = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int unsigned WARM_LAST = (WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0;

  if (NBF_DATA >= NBT_DATA) begin : g_bad_format
    $error("channel_noise_adder: NBF_DATA must be smaller than NBT_DATA");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   warm_cnt;

  logic               v1;
  logic [NBS-1:0]     sum_i;
  logic [NBS-1:0]     sum_q;
  logic [NBT_DATA-1:0] noise_i;
  logic [NBT_DATA-1:0] noise_q;

  function automatic logic [NBT_DATA-1:0] saturate(input logic [NBS-1:0] s);
    if (s[NBS-1] == s[NBS-2]) return s[NBT_DATA-1:0];
    else if (s[NBS-1])        return {1'b1, {(NBT_DATA-1){1'b0}}};
    else                      return {1'b0, {(NBT_DATA-1){1'b1}}};
  endfunction

  // Enable gating: a low enable always wins and returns to IDLE.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      state    <= IDLE;
      warm_cnt <= '0;
    end else if (!i_enable) begin
      state    <= IDLE;
      warm_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          warm_cnt <= '0;
          state    <= (WARMUP_CYCLES == 0) ? RUN : WARMUP;
        end
        WARMUP: begin
          if (warm_cnt == CNT_W'(WARM_LAST)) state <= RUN;
          else                               warm_cnt <= warm_cnt + CNT_W'(1);
        end
        RUN:     state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  // Noise is applied only to samples captured while the FSM sits in RUN.
  assign noise_i = (state == RUN) ? i_noise_I : '0;
  assign noise_q = (state == RUN) ? i_noise_Q : '0;

  always_ff @(posedge clk) begin
    if (!i_reset) begin
      v1    <= 1'b0;
      sum_i <= '0;
      sum_q <= '0;
    end else begin
      v1 <= i_valid;
      if (i_valid) begin
        sum_i <= {i_sym_I[NBT_DATA-1], i_sym_I} + {noise_i[NBT_DATA-1], noise_i};
        sum_q <= {i_sym_Q[NBT_DATA-1], i_sym_Q} + {noise_q[NBT_DATA-1], noise_q};
      end
    end
  end

  // Output stage: saturated samples, held between valid beats.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      o_valid <= 1'b0;
      o_rx_I  <= '0;
      o_rx_Q  <= '0;
    end else begin
      o_valid <= v1;
      if (v1) begin
        o_rx_I <= saturate(sum_i);
        o_rx_Q <= saturate(sum_q);
      end
    end
  end

`ifdef CHANNEL_SAT_CNT_EN
  logic                  sat_hit;
  logic [NB_SAT_CNT-1:0] sat_cnt;

  // One count per sample even if both rails clip; counter is frozen while IDLE.
  assign sat_hit = v1 && (state != IDLE) &&
                   ((sum_i[NBS-1] != sum_i[NBS-2]) || (sum_q[NBS-1] != sum_q[NBS-2]));

  always_ff @(posedge clk) begin
    if (!i_reset)                         sat_cnt <= '0;
    else if (sat_hit && (sat_cnt != '1))  sat_cnt <= sat_cnt + NB_SAT_CNT'(1);
  end

  assign o_sat_count = sat_cnt;
`else
  assign o_sat_count = '0;
`endif

endmodule
